// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the icache/dcache memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: bus widths, default memory latency, FSM state and requester-ID
// enums, the latched-transaction struct and a line-address helper.
package mem_arb_pkg;

  localparam int LINE_W      = 128;
  localparam int ADDR_W      = 15;
  localparam int BE_W        = 16;
  localparam int MEM_LAT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } req_id_e;

  // Everything captured from the winning requester at grant time.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [BE_W-1:0]   be;
    logic [LINE_W-1:0] wdata;
  } txn_t;

  // Lines are 16 bytes, so the low nibble of a byte address is dropped.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(15);
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// 4-bit loadable down-counter with a zero flag, used to time memory accesses.
// Latency: load/decrement take effect on the next rising edge; zero is combinational.
// Backpressure: none; decrement saturates at zero.
//
// Ports: clk, rst (sync, active-high), load + load_val (load wins over dec),
//        dec (count down by one), zero (count == 0).
module mem_lat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory between icache and dcache.
// Latency: grant in IDLE at cycle t -> MEM_LAT access cycles -> ACK at t+MEM_LAT+1.
// Backpressure: requesters hold REQ until their one-cycle ACK; inputs are only sampled in IDLE.
//
// Ports: clk/rst (sync, active-high); icache request/address/ack; dcache
//        request/write/byte-enable/address/wdata/ack; rdata (valid with an ack);
//        memory side ce/per-byte write strobes/line address/wdata/rdata; busy.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int MEM_LAT = MEM_LAT_DEF  // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [BE_W-1:0]   dc_be,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ack,
  output logic [LINE_W-1:0] rdata,
  output logic              mem_ce,
  output logic [BE_W-1:0]   mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;
  localparam logic [1:0] S_RESP   = ST_RESP;

  // Counter is preloaded with MEM_LAT-1 so ACCESS spans exactly MEM_LAT cycles.
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  logic [1:0] state;
  req_id_e    last_gnt;
  req_id_e    gnt;
  req_id_e    pick;
  txn_t       txn;
  txn_t       txn_d;
  logic       any_req;
  logic       cnt_load;
  logic       cnt_zero;

  assign any_req  = ic_req | dc_req;
  assign cnt_load = (state == S_IDLE) && any_req;

  // Dcache wins a lone request, or a tie when icache was served last.
  always_comb begin
    pick = ICACHE;
    if (dc_req && (!ic_req || last_gnt == ICACHE)) begin
      pick = DCACHE;
    end
  end

  // Icache fills are always reads, so its write fields stay zero.
  always_comb begin
    txn_d = '0;
    if (pick == DCACHE) begin
      txn_d.addr  = line_addr(dc_addr);
      txn_d.wr    = dc_wr;
      txn_d.be    = dc_be;
      txn_d.wdata = dc_wdata;
    end else begin
      txn_d.addr  = line_addr(ic_addr);
    end
  end

  mem_lat_counter u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAT_M1),
    .dec      (state == S_ACCESS),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      last_gnt <= ICACHE;
      gnt      <= ICACHE;
      txn      <= '0;
      rdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt      <= pick;
            last_gnt <= pick;
            txn      <= txn_d;
            state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_zero) begin
            // Writes leave rdata untouched so the last read line survives.
            if (!txn.wr) begin
              rdata <= mem_rdata;
            end
            state <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory-side outputs are gated by state so they read zero outside ACCESS.
  assign mem_ce    = (state == S_ACCESS);
  assign mem_addr  = mem_ce ? txn.addr  : '0;
  assign mem_wdata = mem_ce ? txn.wdata : '0;
  assign mem_wr    = (mem_ce && txn.wr) ? txn.be : '0;

  assign ic_ack = (state == S_RESP) && (gnt == ICACHE);
  assign dc_ack = (state == S_RESP) && (gnt == DCACHE);
  assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LAT=4 instance and a MEM_LAT=1 instance.
// Inputs driven and outputs sampled on the falling edge.
module tb_mem_arbiter;

  localparam logic [95:0] PAT = 96'hC0DE_0000_1234_5678_9ABC_DEF0;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cyc = '0;
  logic [127:0] mem_rdata;

  // MEM_LAT=4 instance signals
  logic         ic_req, ic_ack, dc_req, dc_wr, dc_ack, mem_ce, busy;
  logic [14:0]  ic_addr, dc_addr, mem_addr;
  logic [15:0]  dc_be, mem_wr;
  logic [127:0] dc_wdata, rdata, mem_wdata;

  // MEM_LAT=1 instance signals
  logic         b_ic_req, b_ic_ack, b_dc_req, b_dc_wr, b_dc_ack, b_mem_ce, b_busy;
  logic [14:0]  b_ic_addr, b_dc_addr, b_mem_addr;
  logic [15:0]  b_dc_be, b_mem_wr;
  logic [127:0] b_dc_wdata, b_rdata, b_mem_wdata;

  int           n_chk = 0;
  int           n_err = 0;
  logic [127:0] rd_exp;
  logic [127:0] a5_line;
  int           n, ce_n, wr_nz, ack_n;
  logic [15:0]  wr_or;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Memory returns a different line every cycle, so the captured value
  // pins down exactly which ACCESS cycle was sampled.
  assign mem_rdata = {PAT, cyc};

  mem_arbiter #(.MEM_LAT(4)) u_dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_be(dc_be), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_ack(dc_ack),
    .rdata(rdata), .mem_ce(mem_ce), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .ic_req(b_ic_req), .ic_addr(b_ic_addr), .ic_ack(b_ic_ack),
    .dc_req(b_dc_req), .dc_wr(b_dc_wr), .dc_be(b_dc_be), .dc_addr(b_dc_addr),
    .dc_wdata(b_dc_wdata), .dc_ack(b_dc_ack),
    .rdata(b_rdata), .mem_ce(b_mem_ce), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Step until an ACK shows (bounded); records the line a read must return.
  task automatic wait_ack(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!(ic_ack || dc_ack) && cnt < 20);
    rd_exp = {PAT, cyc - 32'd1};
  endtask

  // Watch a window of cycles, counting ACCESS cycles, strobe activity and ACKs;
  // requests drop on the cycle their ACK is seen.
  task automatic observe(input int cycles, output int ce_c, output int wr_c,
                         output int ack_c, output logic [15:0] wr_acc);
    ce_c = 0; wr_c = 0; ack_c = 0; wr_acc = '0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (mem_ce) ce_c++;
      if (mem_wr != 16'h0) wr_c++;
      wr_acc |= mem_wr;
      if (ic_ack || dc_ack) begin
        ack_c++;
        ic_req = 1'b0;
        dc_req = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ic_req = 0; ic_addr = '0; dc_req = 0; dc_wr = 0; dc_be = '0; dc_addr = '0; dc_wdata = '0;
    b_ic_req = 0; b_ic_addr = '0; b_dc_req = 0; b_dc_wr = 0; b_dc_be = '0; b_dc_addr = '0;
    b_dc_wdata = '0;
    a5_line = {16{8'hA5}};

    // ---- reset values
    step(); step();
    check("rst_busy",   busy,      0);
    check("rst_mem_ce", mem_ce,    0);
    check("rst_mem_wr", mem_wr,    0);
    check("rst_addr",   mem_addr,  0);
    check("rst_wdata",  mem_wdata, 0);
    check("rst_rdata",  rdata,     0);
    check("rst_acks",   {ic_ack, dc_ack}, 0);
    rst = 1'b0;

    // ---- lone icache read, address low nibble cleared
    step();
    ic_req = 1; ic_addr = 15'h1237;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("ic_ce_%0d", i),   mem_ce,   1);
      check($sformatf("ic_addr_%0d", i), mem_addr, 15'h1230);
      check($sformatf("ic_noack_%0d", i), ic_ack,  0);
    end
    step();
    check("ic_ack",    {ic_ack, dc_ack}, 2'b10);
    check("ic_resp_ce", mem_ce, 0);
    check("ic_rdata",  rdata, {PAT, cyc - 32'd1});
    ic_req = 0;
    step();
    check("ic_ack_once", ic_ack, 0);
    check("ic_idle",     busy,   0);

    // ---- tie after reset: dcache first, then icache, then dcache again
    rst = 1; step(); rst = 0;
    ic_req = 1; ic_addr = 15'h0A05;
    dc_req = 1; dc_wr = 0; dc_addr = 15'h2468;
    step();
    check("tie1_addr", mem_addr, 15'h2460);
    wait_ack(n);
    check("tie1_lat", n, 4);
    check("tie1_ack", {ic_ack, dc_ack}, 2'b01);
    check("tie1_rdata", rdata, rd_exp);
    dc_req = 0;
    step();
    check("tie_idle", busy, 0);
    step();
    check("tie2_addr", mem_addr, 15'h0A00);
    wait_ack(n);
    check("tie2_lat", n, 4);
    check("tie2_ack", {ic_ack, dc_ack}, 2'b10);
    check("tie2_rdata", rdata, rd_exp);
    dc_req = 1; dc_addr = 15'h3FF1;   // icache still holds: a fresh tie
    step();
    step();
    check("tie3_addr", mem_addr, 15'h3FF0);
    wait_ack(n);
    check("tie3_ack", {ic_ack, dc_ack}, 2'b01);
    check("tie3_rdata", rdata, rd_exp);
    ic_req = 0; dc_req = 0;
    step();

    // ---- dcache write with partial byte enables
    dc_req = 1; dc_wr = 1; dc_be = 16'h00F0; dc_wdata = a5_line; dc_addr = 15'h0155;
    step();
    check("wr_addr",  mem_addr,  15'h0150);
    check("wr_wdata", mem_wdata, a5_line);
    check("wr_strb",  mem_wr,    16'h00F0);
    observe(6, ce_n, wr_nz, ack_n, wr_or);
    check("wr_ce_cycles",  ce_n + 1,  4);
    check("wr_strb_cycles", wr_nz + 1, 4);
    check("wr_strb_bits",  wr_or,  16'h00F0);
    check("wr_ack_count",  ack_n,  1);
    check("wr_rdata_kept", rdata,  rd_exp);

    // ---- dcache write with no byte enables still runs a full access
    dc_req = 1; dc_wr = 1; dc_be = 16'h0000; dc_addr = 15'h0200;
    observe(7, ce_n, wr_nz, ack_n, wr_or);
    check("be0_ce_cycles", ce_n,  4);
    check("be0_strb",      wr_nz, 0);
    check("be0_ack_count", ack_n, 1);
    check("be0_rdata_kept", rdata, rd_exp);

    // ---- reset in the second ACCESS cycle aborts, held request re-granted
    dc_req = 1; dc_wr = 0; dc_be = '0; dc_addr = 15'h4321;
    step();
    step();
    check("abort_pre_ce", mem_ce, 1);
    rst = 1;
    step();
    check("abort_busy",  busy,   0);
    check("abort_ce",    mem_ce, 0);
    check("abort_addr",  mem_addr, 0);
    check("abort_acks",  {ic_ack, dc_ack}, 0);
    check("abort_rdata", rdata,  0);
    rst = 0;
    step();
    check("regrant_addr", mem_addr, 15'h4320);
    wait_ack(n);
    check("regrant_lat",  n, 4);
    check("regrant_ack",  {ic_ack, dc_ack}, 2'b01);
    check("regrant_rdata", rdata, rd_exp);
    dc_req = 0;
    step();

    // ---- MEM_LAT=1, request dropped during ACCESS
    b_dc_req = 1; b_dc_wr = 0; b_dc_addr = 15'h7FFF;
    step();
    check("lat1_ce",   b_mem_ce,   1);
    check("lat1_addr", b_mem_addr, 15'h7FF0);
    b_dc_req = 0;
    step();
    check("lat1_ack",   {b_ic_ack, b_dc_ack}, 2'b01);
    check("lat1_resp_ce", b_mem_ce, 0);
    check("lat1_rdata", b_rdata, {PAT, cyc - 32'd1});
    step();
    check("lat1_ack_once", b_dc_ack, 0);
    check("lat1_idle",     b_busy,   0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 4, memory access cycles per transaction; legal range 1..15.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous and active-high.
REQ-004 IC_REQ  in  1  icache line-fill request; held until IC_ACK.
REQ-005 IC_ADDR  in  15  icache byte address.
REQ-006 IC_ACK  out  1  one-cycle completion pulse to icache.
REQ-007 DC_REQ  in  1  dcache request; held until DC_ACK.
REQ-008 DC_WR  in  1  1 = dcache line write, 0 = line read.
REQ-009 DC_BE  in  16  dcache byte enables, bit i selects byte i of the line.
REQ-010 DC_ADDR  in  15  dcache byte address.
REQ-011 DC_WDATA  in  128  dcache write line.
REQ-012 DC_ACK  out  1  one-cycle completion pulse to dcache.
REQ-013 RDATA  out  128  read line, valid in the cycle IC_ACK or DC_ACK is high.
REQ-014 MEM_CE  out  1  memory chip enable.
REQ-015 MEM_WR  out  16  per-byte write strobes to the main memory, active-high.
REQ-016 MEM_ADDR  out  15  line address to the memory; bits [3:0] are always 0.
REQ-017 MEM_WDATA  out  128  write line to the memory.
REQ-018 MEM_RDATA  in  128  read line from the memory.
REQ-019 BUSY  out  1  high whenever state != IDLE.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP.
REQ-021 IDLE actions:
  - Any REQ sampled high: grant one requester.
  - Latch its address (bits [3:0] forced 0), write flag, BE and WDATA.
  - Load the counter with MEM_LAT-1 and go to ACCESS.
  - Icache requests are always reads.
REQ-022 Arbitration is round-robin on LAST_GNT:
  - When both requests are high, grant the requester not equal to LAST_GNT.
  - A lone request is granted immediately.
  - LAST_GNT updates on every grant.
REQ-023 ACCESS outputs:
  - MEM_CE=1 and MEM_ADDR = latched address.
  - MEM_WDATA = latched data.
  - MEM_WR = latched BE for a dcache write, else 16'h0000.
REQ-024 ACCESS sequencing:
  - The counter decrements each cycle.
  - At count 0, capture MEM_RDATA into RDATA (reads only) and go to RESP.
  - ACCESS lasts exactly MEM_LAT cycles.
REQ-025 RESP: assert the granted requester's ACK for exactly one cycle, MEM_CE=0, MEM_WR=0; go to IDLE next cycle.
REQ-026 Latency: request accepted in IDLE at cycle t gives ACK at cycle t+MEM_LAT+1; the next grant occurs no earlier than t+MEM_LAT+2.
REQ-027 A requester deasserts REQ on the edge at which it samples its ACK; REQ still high in IDLE is a new request.
REQ-028 Outside ACCESS, MEM_CE=0 and MEM_WR=0; IC_ACK and DC_ACK are never high together.
REQ-029 REQ dropped during ACCESS is ignored; the transaction completes and is still ACKed.
REQ-030 Requester inputs are not sampled outside IDLE; changes during ACCESS/RESP have no effect.
REQ-031 RDATA holds its previous value across a write transaction.
REQ-032 A dcache write with DC_BE=0 runs a full ACCESS with MEM_WR=0 and is ACKed normally.

Reset
REQ-033 RST values:
  - State=IDLE, LAST_GNT=ICACHE (dcache wins the first tie), counter=0.
  - IC_ACK=DC_ACK=0, MEM_CE=0, MEM_WR=0, MEM_ADDR=0, MEM_WDATA=0, RDATA=0, BUSY=0.
REQ-034 RST asserted mid-transaction aborts it with no ACK; a requester still holding REQ is re-arbitrated from IDLE after RST deasserts.

Structure
REQ-035 Package mem_arb_pkg holds:
  - the state enum and the requester-ID enum (ICACHE, DCACHE);
  - LINE_W=128, ADDR_W=15, BE_W=16;
  - the MEM_LAT default.
REQ-036 Sub-module mem_lat_counter: 4-bit loadable down-counter with a zero flag.

Verification
REQ-037 Lone IC_REQ, IC_ADDR=15'h1237, MEM_LAT=4 -> MEM_ADDR=15'h1230 and MEM_CE=1 for 4 cycles; IC_ACK at t+5 with RDATA = MEM_RDATA from the last ACCESS cycle.
REQ-038 IC_REQ and DC_REQ rise together after reset -> dcache granted first; icache granted in the IDLE cycle after DC_ACK; a further tie grants dcache again.
REQ-039 DC write, DC_BE=16'h00F0, DC_WDATA=128'hA5.. -> MEM_WR=16'h00F0 for exactly MEM_LAT cycles, DC_ACK once, RDATA unchanged.
REQ-040 RST asserted in the second ACCESS cycle -> next cycle all outputs at reset values, no ACK; held DC_REQ re-granted afterward.
REQ-041 MEM_LAT=1 and DC_REQ dropped mid-ACCESS -> ACCESS lasts 1 cycle and DC_ACK is still issued at t+2.
